// File: rtl/piso_shift_register.sv
// piso_shift_register
//   Parallel-in serial-out shift register. A WIDTH-bit word is captured through
//   a valid/ready handshake, then streamed one bit per cycle in which the sink
//   asserts shift_en_i. A word may be loaded on the final bit of the current
//   frame, so frames can run back to back with no gap cycle.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous reset, active-high
//   load_valid_i    parallel_in_i holds a word to transmit
//   load_ready_o    block accepts a word this cycle (combinational)
//   parallel_in_i   word to serialise, sampled on load accept
//   shift_en_i      sink consumes the current bit this cycle
//   serial_out_o    current serial bit, 0 when serial_valid_o=0
//   serial_valid_o  serial_out_o carries a frame bit
//   last_o          current bit is the final bit of the frame
//   done_o          one-cycle pulse, the cycle after the final bit is consumed
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no frame in flight, ready for a word
// SHIFT | frame in flight, shreg_q holds the not-yet-consumed bits

module piso_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] parallel_in_i,
  input  logic             shift_en_i,
  output logic             serial_out_o,
  output logic             serial_valid_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shreg_shifted;
  logic             in_shift;
  logic             last;
  logic             accept;

  assign in_shift = (state_q == SHIFT);
  assign last     = in_shift && (cnt_q == CNT_LAST);

  // Ready is gated by reset so that nothing can be accepted while the block
  // is held in reset, even though the state register already reads IDLE.
  assign load_ready_o = ~rst_i & ((state_q == IDLE) | (last & shift_en_i));
  assign accept       = load_valid_i & load_ready_o;

  // Shift toward the output end, zero-filling the vacated position.
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  assign serial_valid_o = in_shift;
  assign serial_out_o   = in_shift & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign last_o         = last;
  assign done_o         = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = parallel_in_i;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (shift_en_i) begin
          if (last) begin
            done_d = 1'b1;
            if (accept) begin
              // Reload on the final bit: next frame starts without a gap.
              shreg_d = parallel_in_i;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_register.sv
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  // MSB-first instance
  logic       lv1, lr1, sen1, so1, sv1, la1, dn1;
  logic [3:0] pin1;
  // LSB-first instance
  logic       lv0, lr0, sen0, so0, sv0, la0, dn0;
  logic [3:0] pin0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(lv1), .load_ready_o(lr1), .parallel_in_i(pin1),
    .shift_en_i(sen1), .serial_out_o(so1), .serial_valid_o(sv1),
    .last_o(la1), .done_o(dn1)
  );

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(lv0), .load_ready_o(lr0), .parallel_in_i(pin0),
    .shift_en_i(sen0), .serial_out_o(so0), .serial_valid_o(sv0),
    .last_o(la0), .done_o(dn0)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check all outputs of the MSB-first instance.
  task automatic chk1(input string tag, input logic sv, input logic so,
                      input logic la, input logic dn, input logic lr);
    chk({tag, ".serial_valid"}, sv1, sv);
    chk({tag, ".serial_out"},   so1, so);
    chk({tag, ".last"},         la1, la);
    chk({tag, ".done"},         dn1, dn);
    chk({tag, ".load_ready"},   lr1, lr);
  endtask

  task automatic chk0(input string tag, input logic sv, input logic so,
                      input logic la, input logic dn, input logic lr);
    chk({tag, ".serial_valid"}, sv0, sv);
    chk({tag, ".serial_out"},   so0, so);
    chk({tag, ".last"},         la0, la);
    chk({tag, ".done"},         dn0, dn);
    chk({tag, ".load_ready"},   lr0, lr);
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lv1 = 1'b0; sen1 = 1'b0; pin1 = 4'h0;
    lv0 = 1'b0; sen0 = 1'b0; pin0 = 4'h0;

    // 1. reset
    #2;
    chk1("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv(); adv();
    smp();
    chk1("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    rst = 1'b0;
    smp();
    chk1("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // shift_en in IDLE has no effect
    adv();
    sen1 = 1'b1;
    smp();
    chk1("idle_sen", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    adv();

    // 2. load 1011 MSB first, continuous shift
    lv1 = 1'b1; pin1 = 4'b1011; sen1 = 1'b1;
    smp();
    chk1("t2_acc", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    adv();
    lv1 = 1'b0; pin1 = 4'b0000;   // change after accept must not matter
    smp(); chk1("t2_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t2_b2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t2_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t2_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); adv();
    smp(); chk1("t2_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); adv();
    smp(); chk1("t2_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3. load 0110, stalls
    lv1 = 1'b1; pin1 = 4'b0110; sen1 = 1'b1;
    adv();
    lv1 = 1'b0;
    sen1 = 1'b1; smp(); chk1("t3_c1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    sen1 = 1'b0; smp(); chk1("t3_c2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    sen1 = 1'b0; smp(); chk1("t3_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    sen1 = 1'b1; smp(); chk1("t3_c4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    sen1 = 1'b1; smp(); chk1("t3_c5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    sen1 = 1'b1; smp(); chk1("t3_c6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); adv();
    smp(); chk1("t3_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); adv();
    smp(); chk1("t3_once", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4. back-to-back frames 1011 then 1001
    lv1 = 1'b1; pin1 = 4'b1011; sen1 = 1'b1;
    adv();
    lv1 = 1'b0;
    smp(); chk1("t4_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t4_b2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t4_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    lv1 = 1'b1; pin1 = 4'b1001;
    smp(); chk1("t4_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); adv();
    lv1 = 1'b0; pin1 = 4'b0000;
    smp(); chk1("t4_b5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); adv();
    smp(); chk1("t4_b6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t4_b7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t4_b8", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); adv();
    smp(); chk1("t4_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); adv();

    // 5. reset mid-frame
    lv1 = 1'b1; pin1 = 4'b1111; sen1 = 1'b1;
    adv();
    lv1 = 1'b0;
    smp(); chk1("t5_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t5_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    rst = 1'b1;
    #1;
    chk1("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    smp(); chk1("t5_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    rst = 1'b0;
    smp(); chk1("t5_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); adv();
    smp(); chk1("t5_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lv1 = 1'b1; pin1 = 4'b0001;
    adv();
    lv1 = 1'b0;
    smp(); chk1("t5_n1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t5_n2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t5_n3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk1("t5_n4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); adv();
    smp(); chk1("t5_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    sen1 = 1'b0;

    // 6. LSB first, load 1011, ignored load_valid mid-frame
    smp(); chk0("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lv0 = 1'b1; pin0 = 4'b1011; sen0 = 1'b1;
    adv();
    lv0 = 1'b0;
    smp(); chk0("t6_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    lv0 = 1'b1; pin0 = 4'b0000;
    smp(); chk0("t6_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); adv();
    lv0 = 1'b0;
    smp(); chk0("t6_b3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
    smp(); chk0("t6_b4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); adv();
    smp(); chk0("t6_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); adv();
    smp(); chk0("t6_post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
